rs_issue_select: RTL
====================

Name: rs_issue_select

Overview:
- Sits between a bank of NUM_RS forwarding reservation stations and one execution unit.
- Dispatch side: steers the decode write enable into the lowest-index free station, and back-pressures decode when every station is busy.
- Issue side: each cycle, grants exactly one ready station using round-robin order. It holds all other ready stations via their stall inputs and captures the winner's operands, commands and ROB tag into a registered valid/ready issue slot that feeds execute.

Parameters:
- NUM_RS, 4, number of reservation stations served (2..8).
- ROBsize, 8, ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), ROB tag width. Tag 0 means "no tag".

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- decodeWriteEn_i  in  1  decode has an instruction to place.
- decodeStall_o  out  1  all stations are busy; decode must hold.
- rsWriteEn_o  out  NUM_RS  one-hot write enable, driven to each station's decodeWriteEn_i.
- rsBusy_i  in  NUM_RS  busy_o from each station.
- rsReady_i  in  NUM_RS  ready_o from each station.
- rsVal1_i, rsVal2_i, rsVal3_i  in  NUM_RS*64  each station's operand outputs; station i occupies bits [64i+63:64i].
- rsCommands_i  in  NUM_RS*10  each station's command outputs.
- rsTag_i  in  NUM_RS*ROBsizeLog  each station's destination ROB tag.
- rsStall_o  out  NUM_RS  drives each station's stall_i.
- flush_i  in  1  mispredict flush.
- execReady_i  in  1  execute accepts the issue slot this cycle.
- execValid_o  out  1  issue slot holds a valid instruction.
- execVal1_o, execVal2_o, execVal3_o  out  64  registered operands.
- execCommands_o  out  10  registered commands.
- execTag_o  out  ROBsizeLog  registered destination tag.
- issueCount_o  out  16  saturating count of accepted issues.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - execValid_o=0; all exec data outputs=0; issueCount_o=0.
  - Round-robin pointer=0.
  - Combinational outputs follow their rules below with the registers at these values.
- Dispatch (combinational):
  - free = ~rsBusy_i.
  - rsWriteEn_o = lowest-index set bit of free, gated by decodeWriteEn_i.
  - decodeStall_o = decodeWriteEn_i & (free==0).
  - A station issuing this cycle is still busy, so it is never also the dispatch target that cycle.
- Slot acceptance: slotOpen = ~execValid_o | execReady_i.
- Grant (combinational):
  - Candidate set = rsReady_i & {NUM_RS{slotOpen & ~flush_i}}.
  - Search starts at pointer p, wrapping through NUM_RS-1 then 0; the first candidate wins. If there are no candidates, there is no grant.
- Stall outputs: rsStall_o[i] = ~grant[i] for every i.
  - Non-granted ready stations stay busy and hold their operands (forwarding continues inside them).
  - The granted station frees next edge.
- Issue register, updated on rising edge:
  - flush_i=1: execValid_o←0 and data is held. Flush has priority over everything.
  - Else if slotOpen: execValid_o←|grant. If there is a grant, data←the granted station's val1/val2/val3/commands/tag.
  - Else: everything holds.
- Issue latency: a station ready in cycle N appears on exec outputs in cycle N+1 if granted.
- Execute handshake: an instruction is consumed when execValid_o & execReady_i.
  - Back-to-back issue at one per cycle is supported while execReady_i=1.
  - execReady_i=0 with a valid slot: no grant, all ready stations stall.
- Pointer:
  - On a grant to station g: p←(g+1) mod NUM_RS.
  - With no grant: p holds.
  - flush_i does not move p.
- issueCount_o: increments on each edge where execValid_o & execReady_i & ~flush_i. It saturates at 16'hFFFF and does not wrap.
- Reset asserted mid-operation: the slot is dropped immediately and asynchronously. The stations are reset by the same reset_i.

Test Plan:
- Reset then idle, all rsBusy_i=0 -> execValid_o=0, rsStall_o=4'b1111, decodeStall_o=0.
- decodeWriteEn_i=1, rsBusy_i=4'b0101 -> rsWriteEn_o=4'b0010. With rsBusy_i=4'b1111 -> rsWriteEn_o=0 and decodeStall_o=1.
- Round-robin fairness: rsReady_i=4'b1111 held, execReady_i=1, p=0 -> grants go to stations 0,1,2,3,0 on consecutive cycles. execTag_o follows the rsTag_i values (e.g. tags 3,5,6,7) one cycle later, and issueCount_o=4 after four accepted cycles.
- Back-pressure: slot valid with tag 5, execReady_i=0 for 3 cycles, station 2 ready -> execTag_o stays 5, rsStall_o[2]=1 throughout. When execReady_i returns to 1, station 2 is granted the same cycle and its tag appears next cycle.
- Flush: execValid_o=1, rsReady_i=4'b0010, flush_i=1 for 1 cycle -> execValid_o=0 next cycle, no grant that cycle, p unchanged. Station 1 is issued the following cycle.
- Asynchronous reset mid-stream: reset_i low between clock edges with execValid_o=1 -> execValid_o=0 and issueCount_o=0 immediately. After release, the first grant goes to the lowest ready station from p=0.

Source files
------------

// File: rtl/rs_issue_select.sv
// Dispatch steering and round-robin issue select between a bank of reservation
// stations and a single execution unit. The issue slot is registered.
module rs_issue_select #(
  parameter int unsigned NUM_RS     = 4,
  parameter int unsigned ROBsize    = 8,
  parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         decodeWriteEn_i,
  output logic                         decodeStall_o,
  output logic [NUM_RS-1:0]            rsWriteEn_o,
  input  logic [NUM_RS-1:0]            rsBusy_i,
  input  logic [NUM_RS-1:0]            rsReady_i,
  input  logic [NUM_RS*64-1:0]         rsVal1_i,
  input  logic [NUM_RS*64-1:0]         rsVal2_i,
  input  logic [NUM_RS*64-1:0]         rsVal3_i,
  input  logic [NUM_RS*10-1:0]         rsCommands_i,
  input  logic [NUM_RS*ROBsizeLog-1:0] rsTag_i,
  output logic [NUM_RS-1:0]            rsStall_o,
  input  logic                         flush_i,
  input  logic                         execReady_i,
  output logic                         execValid_o,
  output logic [63:0]                  execVal1_o,
  output logic [63:0]                  execVal2_o,
  output logic [63:0]                  execVal3_o,
  output logic [9:0]                   execCommands_o,
  output logic [ROBsizeLog-1:0]        execTag_o,
  output logic [15:0]                  issueCount_o
);

  localparam int unsigned PtrW = $clog2(NUM_RS);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_RS - 1);

  logic [NUM_RS-1:0]     free;
  logic [NUM_RS-1:0]     cand;
  logic [NUM_RS-1:0]     grant;
  logic                  slot_open;
  logic                  any_grant;
  logic                  disp_found;
  logic                  gnt_found;
  logic [PtrW-1:0]       gnt_idx;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic [63:0]           val1_q, val1_d;
  logic [63:0]           val2_q, val2_d;
  logic [63:0]           val3_q, val3_d;
  logic [9:0]            cmd_q, cmd_d;
  logic [ROBsizeLog-1:0] tag_q, tag_d;
  logic [15:0]           cnt_q, cnt_d;

  assign free          = ~rsBusy_i;
  assign decodeStall_o = decodeWriteEn_i & (free == '0);

  always_comb begin
    rsWriteEn_o = '0;
    disp_found  = 1'b0;
    for (int i = 0; i < int'(NUM_RS); i++) begin
      if (!disp_found && free[i]) begin
        disp_found     = 1'b1;
        rsWriteEn_o[i] = decodeWriteEn_i;
      end
    end
  end

  assign slot_open = ~valid_q | execReady_i;
  assign cand      = rsReady_i & {NUM_RS{slot_open & ~flush_i}};

  // Circular search starting at the round-robin pointer.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < int'(NUM_RS); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(NUM_RS)) idx = idx - int'(NUM_RS);
      if (!gnt_found && cand[idx]) begin
        gnt_found  = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PtrW'(idx);
      end
    end
  end

  assign any_grant = |grant;
  assign rsStall_o = ~grant;

  always_comb begin
    valid_d = valid_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    val3_d  = val3_q;
    cmd_d   = cmd_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (valid_q && execReady_i && !flush_i && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (slot_open) begin
      valid_d = any_grant;
      if (any_grant) begin
        val1_d = rsVal1_i[int'(gnt_idx)*64 +: 64];
        val2_d = rsVal2_i[int'(gnt_idx)*64 +: 64];
        val3_d = rsVal3_i[int'(gnt_idx)*64 +: 64];
        cmd_d  = rsCommands_i[int'(gnt_idx)*10 +: 10];
        tag_d  = rsTag_i[int'(gnt_idx)*int'(ROBsizeLog) +: ROBsizeLog];
        ptr_d  = (gnt_idx == LastIdx) ? '0 : gnt_idx + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= 1'b0;
      val1_q  <= '0;
      val2_q  <= '0;
      val3_q  <= '0;
      cmd_q   <= '0;
      tag_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
      val3_q  <= val3_d;
      cmd_q   <= cmd_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign execValid_o    = valid_q;
  assign execVal1_o     = val1_q;
  assign execVal2_o     = val2_q;
  assign execVal3_o     = val3_q;
  assign execCommands_o = cmd_q;
  assign execTag_o      = tag_q;
  assign issueCount_o   = cnt_q;

endmodule
